// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   NUM_REQ : number of requesters (fixed at 4 to match the 4:1 data mux)
//   SEL_W   : width of the mux select / requester index
//   CNT_W   : width of the optional grant timeout counter
//   arb_state_e : FSM encoding, ST_IDLE / ST_GRANT
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
//   req  : request vector
//   ptr  : highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   mask : requests to ignore (current owner during a release pick)
//   any  : at least one unmasked request
//   idx  : index of the winning request (0 when any is low)
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_cand;
  logic [SEL_W-1:0]   w_pos;

  assign w_cand = req & ~mask;
  assign any    = |w_cand;

  // Walk from the lowest-priority offset up so the highest-priority hit is written last.
  always_comb begin
    idx   = '0;
    w_pos = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_pos = ptr + SEL_W'(k - 1);
      if (w_cand[w_pos]) idx = w_pos;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit resource port among four requesters
// (fetch, load/store, debug, DMA). Holds each grant until ack, abort or timeout,
// then rotates priority past the previous owner with zero bubble cycles.
//   clk_i     : clock, rising edge
//   rst_n_i   : asynchronous active-low reset
//   req_i     : per-requester level request
//   ack_i     : single-cycle transaction-complete pulse from the resource
//   gnt_o     : registered one-hot grant, zero when idle
//   select_o  : registered mux select (index of granted requester)
//   valid_o   : transaction active, equals |gnt_o
//   timeout_o : one-cycle pulse on forced release
// Optional feature: define ARB_TIMEOUT_EN to enable the grant timeout counter
// (TIMEOUT_CYCLES, 1..255). Without it timeout_o is tied low.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0]   select_o,
  output logic               valid_o,
  output logic               timeout_o
);

  arb_state_e         r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;

  logic               w_in_grant;
  logic               w_abort;
  logic               w_tmo;
  logic               w_release;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [NUM_REQ-1:0] w_pick_mask;
  logic               w_any;
  logic [SEL_W-1:0]   w_idx;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;
  assign w_tmo = w_in_grant && !ack_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_abort    = !req_i[r_sel];
  assign w_release  = w_in_grant && (ack_i || w_abort || w_tmo);

  // One picker serves both cases: IDLE uses the stored pointer unmasked; a release
  // uses owner+1 with the owner masked so it cannot win back-to-back over others.
  assign w_pick_ptr  = w_in_grant ? (r_sel + SEL_W'(1)) : r_ptr;
  assign w_pick_mask = w_in_grant ? r_gnt : '0;

  rr_pick u_pick (
    .req  (req_i),
    .ptr  (w_pick_ptr),
    .mask (w_pick_mask),
    .any  (w_any),
    .idx  (w_idx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tmo <= w_tmo;
      // Counter restarts on every grant (new or re-issued) and runs while held.
      if (w_in_grant && !w_release) r_cnt <= r_cnt + CNT_W'(1);
      else                          r_cnt <= '0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= NUM_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_ptr <= r_sel + SEL_W'(1);
            if (w_any) begin
              r_gnt <= NUM_REQ'(1) << w_idx;
              r_sel <= w_idx;
            end else if (!req_i[r_sel]) begin
              // Nobody else waiting and the owner is done: go idle, select keeps value.
              r_gnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o    = r_gnt;
  assign select_o = r_sel;
  assign valid_o  = |r_gnt;
`ifdef ARB_TIMEOUT_EN
  assign timeout_o = r_tmo;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk_i;
  logic       rst_n_i;
  logic [3:0] req_i;
  logic       ack_i;
  logic [3:0] gnt_o;
  logic [1:0] select_o;
  logic       valid_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       tmo;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .gnt_o     (gnt_o),
    .select_o  (select_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.name, "gnt",     int'(gnt_o),     int'(e.gnt));
    cmp(e.name, "sel",     int'(select_o),  int'(e.sel));
    cmp(e.name, "valid",   int'(valid_o),   int'(|e.gnt));
    cmp(e.name, "timeout", int'(timeout_o), int'(e.tmo));
  endtask

  task automatic expect_now(input logic [3:0] g, input logic [1:0] s, input logic t,
                            input string nm);
    exp_t e;
    e.gnt = g; e.sel = s; e.tmo = t; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive inputs mid-cycle, queue the expectation, sample just after the next edge.
  task automatic step(input logic [3:0] r, input logic a, input logic [3:0] g,
                      input logic [1:0] s, input logic t, input string nm);
    @(negedge clk_i);
    req_i = r;
    ack_i = a;
    expect_now(g, s, t, nm);
    @(posedge clk_i);
    #1;
    check_out();
  endtask

  task automatic add(input logic [3:0] r, input logic a, input logic [3:0] g,
                     input logic [1:0] s, input string nm);
    vec_t v;
    v.req = r; v.ack = a; v.gnt = g; v.sel = s; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    // Round robin with all requesting, ack on the 3rd grant cycle (ptr starts at 0).
    add(4'b1111, 1'b0, 4'b0001, 2'd0, "rr_g0");
    add(4'b1111, 1'b0, 4'b0001, 2'd0, "rr_g0_h1");
    add(4'b1111, 1'b0, 4'b0001, 2'd0, "rr_g0_h2");
    add(4'b1111, 1'b1, 4'b0010, 2'd1, "rr_g1");
    add(4'b1111, 1'b0, 4'b0010, 2'd1, "rr_g1_h1");
    add(4'b1111, 1'b0, 4'b0010, 2'd1, "rr_g1_h2");
    add(4'b1111, 1'b1, 4'b0100, 2'd2, "rr_g2");
    add(4'b1111, 1'b0, 4'b0100, 2'd2, "rr_g2_h1");
    add(4'b1111, 1'b0, 4'b0100, 2'd2, "rr_g2_h2");
    add(4'b1111, 1'b1, 4'b1000, 2'd3, "rr_g3");
    add(4'b1111, 1'b0, 4'b1000, 2'd3, "rr_g3_h1");
    add(4'b1111, 1'b0, 4'b1000, 2'd3, "rr_g3_h2");
    add(4'b1111, 1'b1, 4'b0001, 2'd0, "rr_wrap0");
    add(4'b0000, 1'b1, 4'b0000, 2'd0, "rr_idle");            // ptr -> 1
    // Owner still requesting.
    add(4'b0011, 1'b0, 4'b0010, 2'd1, "own_g1");             // ptr 1 picks 1
    add(4'b0011, 1'b1, 4'b0001, 2'd0, "own_g0");
    add(4'b0011, 1'b1, 4'b0010, 2'd1, "own_0to1");
    add(4'b0010, 1'b1, 4'b0010, 2'd1, "own_regrant1");       // ptr -> 2
    add(4'b0000, 1'b0, 4'b0000, 2'd1, "own_abort_idle");     // sel holds in IDLE
    // Abort handover and simultaneous ack+abort.
    add(4'b0100, 1'b0, 4'b0100, 2'd2, "abt_g2");
    add(4'b0100, 1'b0, 4'b0100, 2'd2, "abt_g2_h");
    add(4'b1000, 1'b0, 4'b1000, 2'd3, "abt_to3");
    add(4'b0000, 1'b1, 4'b0000, 2'd3, "ack_abort_idle");     // ptr -> 0
    add(4'b0000, 1'b1, 4'b0000, 2'd3, "ack_in_idle");
    add(4'b0001, 1'b1, 4'b0001, 2'd0, "idle_ack_ignored");
    add(4'b0000, 1'b1, 4'b0000, 2'd0, "back_idle");          // ptr -> 1

    req_i   = 4'b0000;
    ack_i   = 1'b0;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    expect_now(4'b0000, 2'd0, 1'b0, "reset");
    check_out();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    foreach (vecs[i]) step(vecs[i].req, vecs[i].ack, vecs[i].gnt, vecs[i].sel, 1'b0,
                           vecs[i].name);

    // Asynchronous reset mid-transaction.
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "pre_rst_g3");
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    expect_now(4'b0000, 2'd0, 1'b0, "async_rst");
    check_out();
    req_i = 4'b0000;
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Requester 1 never acked; requester 2 waiting.
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "tmo_c1");
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "tmo_c2");
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "tmo_c3");
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "tmo_c4");
`ifdef ARB_TIMEOUT_EN
    step(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, "tmo_fire");
    step(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0, "tmo_pulse_end");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, "tmo_idle");
`else
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "hold_c5");
    step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "hold_c6");
    step(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, "hold_idle");
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one 32-bit resource port (data memory / bus slave) among four requesters: instruction fetch, load/store unit, debug, and DMA. It owns the 2-bit `select_i` of the 4:1 32-bit data mux in front of the port and sequences one transaction at a time. It holds each grant until the resource acknowledges, then rotates priority so that no requester starves. The block sits between the requesters and the shared port in the CPU top level.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 to match the 4:1 mux.
- `TIMEOUT_CYCLES`, 255: grant cycles without `ack_i` before forced release. Only used when `ARB_TIMEOUT_EN` is defined. Range 1..255.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous assert, active-low.
- `req_i`  in  4  per-requester request, level. Bit k is held high until served.
- `ack_i`  in  1  resource completed the current transaction (single-cycle pulse).
- `gnt_o`  out  4  one-hot grant, registered; all zero when idle.
- `select_o`  out  2  mux select (index of the granted requester), registered.
- `valid_o`  out  1  transaction active toward the resource; equals `|gnt_o`.
- `timeout_o`  out  1  one-cycle pulse on forced release. Tied to 0 when `ARB_TIMEOUT_EN` is not defined.

## Operation
- States: IDLE, GRANT.
- Priority pointer `ptr` (2 bits) marks the highest-priority index. The search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- **IDLE:**
  - If `req_i` is nonzero, pick the winner `w` by the search order.
  - Register `gnt_o = 1<<w` and `select_o = w`, then go to GRANT.
  - Otherwise stay in IDLE with `gnt_o = 0`.
- **GRANT, release event:** a release event is any of:
  - `ack_i`;
  - `req_i[select_o]` dropped (abort);
  - timeout.
- **GRANT, on release:**
  - Set `ptr <= select_o + 1` (wraps from 3 to 0).
  - Re-arbitrate in the same cycle using the new `ptr` against `req_i`, with the current owner's bit masked. The owner is therefore never re-granted back-to-back while others wait.
  - If the re-arbitration produces a winner, stay in GRANT with the new `gnt_o`/`select_o`.
  - If no other request is pending but the owner still requests, re-grant the owner.
  - If nothing is requesting, go to IDLE and clear `gnt_o`.
- **GRANT, no release event:** `gnt_o`, `select_o` and `ptr` hold.
- `ack_i` while in IDLE is ignored.
- Simultaneous `ack_i` and abort on the same cycle count as one release.
- `select_o` keeps its last value in IDLE. Only `gnt_o`/`valid_o` indicate validity.

## Timing
- Reset values: state IDLE, `gnt_o = 4'b0000`, `select_o = 2'b00`, `valid_o = 0`, `timeout_o = 0`, `ptr = 0`, timeout counter 0.
- Request-to-grant latency: 1 cycle (`req_i` sampled in IDLE at edge n gives `gnt_o` at n+1).
- Handover on `ack_i` has zero bubble cycles: the new grant is visible on the edge after `ack_i`.
- Reset asserted mid-transaction drops `gnt_o` immediately (asynchronously), without waiting for `ack_i`.
- No combinational path from `req_i` or `ack_i` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on every grant change and increments each GRANT cycle without `ack_i`.
  - When the counter reaches `TIMEOUT_CYCLES - 1` and `ack_i` is low, the arbiter forces a release and pulses `timeout_o` for 1 cycle.
- **Undefined:**
  - No counter is present and `timeout_o` is driven 0.
  - A grant holds indefinitely until `ack_i` or abort.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding localparams `ST_IDLE`/`ST_GRANT`;
  - `NUM_REQ`;
  - `SEL_W = 2`;
  - timeout counter width.
- Sub-module `rr_pick`: combinational rotating-priority encoder. Inputs are `req[3:0]`, `ptr[1:0]` and `mask[3:0]`. Outputs are `any` and `idx[1:0]`. It is instantiated once and used for both the IDLE pick and the release pick.
- The top level holds the FSM, `ptr`, grant registers and the optional timeout counter.

## Test plan
- **Reset:** after reset, `gnt_o = 0000`, `select_o = 00`, `valid_o = 0`. Asserting `rst_n_i` low during GRANT clears `gnt_o` before the next edge.
- **Single requester:** `req_i = 0100` → `gnt_o = 0100` and `select_o = 10` one cycle later. `ack_i` with `req_i` dropped → IDLE, `gnt_o = 0000`.
- **Round-robin, all requesting:** `req_i = 1111` held, `ack_i` every 3rd cycle → grant order 0, 1, 2, 3, 0, with no idle cycle between grants.
- **Owner still requesting:** `req_i = 0011`, owner 0 acks while still requesting → next grant goes to 1. Then `req_i = 0010` only and 1 acks → re-grant to 1.
- **Abort:** granted requester 2 drops `req_i[2]` with no `ack_i`, `req_i = 1000` → `gnt_o = 1000` on the next edge.
- **Timeout:** with `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES = 4`, granted requester 1 never sees `ack_i` → `timeout_o` pulses 1 cycle after the 4th grant cycle, and the grant moves to the next pending requester.
